// File: rtl/ipd_pkg.sv
// ipd_pkg -- shared definitions for the IPD controller datapath.
//
// Contents:
//   IPD_STAGES  : pipeline depth, which is also the sample-to-result latency.
//   ipd_acc_t   : wide signed type. Every add, subtract and product is
//                 evaluated exactly at this width and then saturated.
//   ipd_sat_max / ipd_sat_min : saturation limits of a w-bit signed word.
//   ipd_sat     : clips a wide value into the w-bit signed range.
//   ipd_clamp   : symmetric clamp to [-lim, lim], used for integrator anti-windup.
//
// Limitation: WIDTH must satisfy 2*WIDTH <= IPD_ACC_W.
package ipd_pkg;

    localparam int IPD_STAGES = 4;
    localparam int IPD_ACC_W  = 128;

    typedef logic signed [IPD_ACC_W-1:0] ipd_acc_t;

    function automatic ipd_acc_t ipd_sat_max(input int w);
        return (ipd_acc_t'(1) <<< (w - 1)) - ipd_acc_t'(1);
    endfunction

    function automatic ipd_acc_t ipd_sat_min(input int w);
        return -(ipd_acc_t'(1) <<< (w - 1));
    endfunction

    function automatic ipd_acc_t ipd_sat(input ipd_acc_t x, input int w);
        if (x > ipd_sat_max(w)) begin
            return ipd_sat_max(w);
        end else if (x < ipd_sat_min(w)) begin
            return ipd_sat_min(w);
        end
        return x;
    endfunction

    function automatic ipd_acc_t ipd_clamp(input ipd_acc_t x, input ipd_acc_t lim);
        if (x > lim) begin
            return lim;
        end else if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

endpackage

// File: rtl/ipd_fxp_mul.sv
// ipd_fxp_mul -- combinational fixed-point multiply with saturation.
//
// The product is formed exactly at 2*WIDTH bits. It is then arithmetic-shifted
// right by PRECISION, which drops the extra fractional bits and rounds toward
// minus infinity. Finally it is saturated to the WIDTH-bit signed range.
//
// Parameters:
//   WIDTH     : signed operand and result width
//   PRECISION : number of fractional bits in the shared fixed-point format
//
// Ports:
//   a, b : signed operands (WIDTH bits)
//   p    : saturated product (WIDTH bits)
module ipd_fxp_mul
    import ipd_pkg::*;
#(
    parameter int WIDTH     = 19,
    parameter int PRECISION = 0
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;

    assign prod    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign prod_sh = prod >>> PRECISION;
    assign p       = WIDTH'(ipd_sat(ipd_acc_t'(prod_sh), WIDTH));

endmodule

// File: rtl/ipd_controller.sv
// ipd_controller -- pipelined I-PD controller.
//
// For each accepted sample the controller computes:
//   e  = r - y
//   dy = y - y_prev
//   p  = kp*y
//   d  = kd*dy
//   I += ki*e
//   u  = I - p - d
//
// The work is spread over four stages:
//   S1 : e, dy
//   S2 : the three products
//   S3 : integrator update and pd = -p - d
//   S4 : u = I + pd
// Every add and subtract is evaluated exactly and then saturated to WIDTH bits.
//
// Optional feature:
//   IPD_ANTIWINDUP_EN : when defined, the integrator is also clamped to
//                       [-INT_LIMIT, INT_LIMIT].
//
// Parameters:
//   WIDTH     : data width
//   PRECISION : fractional bits
//   INT_LIMIT : integrator clamp magnitude
//
// Ports:
//   clock, reset     : sole clock; synchronous active-high reset
//   enable           : pipeline advance; when low, every register holds
//   clear_int        : zeroes the integrator (only when enable is high)
//   in_valid         : sample strobe; a sample is taken only when enable is also high
//   referencia, y_k  : reference and plant output
//   kp, ki, kd       : gains; unregistered, sampled while a sample is in S2
//   out_valid        : one pulse per result
//   salida_IPD       : control effort u
//   prop, integral, derivativa : p, I and d belonging to the same result
module ipd_controller
    import ipd_pkg::*;
#(
    parameter int WIDTH     = 19,
    parameter int PRECISION = 0,
    parameter int INT_LIMIT = 2**(WIDTH-1)-1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear_int,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] referencia,
    input  logic signed [WIDTH-1:0] y_k,
    input  logic signed [WIDTH-1:0] kp,
    input  logic signed [WIDTH-1:0] ki,
    input  logic signed [WIDTH-1:0] kd,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] salida_IPD,
    output logic signed [WIDTH-1:0] prop,
    output logic signed [WIDTH-1:0] integral,
    output logic signed [WIDTH-1:0] derivativa
);

`ifdef IPD_ANTIWINDUP_EN
    localparam bit AW_EN = 1'b1;
`else
    localparam bit AW_EN = 1'b0;
`endif

    function automatic ipd_acc_t ext(input logic signed [WIDTH-1:0] v);
        return ipd_acc_t'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_w(input ipd_acc_t x);
        return WIDTH'(ipd_sat(x, WIDTH));
    endfunction

    // Bit k of vld is the valid flag of the sample held in stage k.
    logic [IPD_STAGES:1] vld;

    logic signed [WIDTH-1:0] y_prev;
    logic signed [WIDTH-1:0] y_p1, e_p1, dy_p1;
    logic signed [WIDTH-1:0] p_mul, inc_mul, d_mul;
    logic signed [WIDTH-1:0] p_p2, inc_p2, d_p2;
    logic signed [WIDTH-1:0] p_p3, d_p3, pd_p3, int_p3;
    logic signed [WIDTH-1:0] u_p4, p_p4, d_p4, i_p4;
    logic signed [WIDTH-1:0] int_sum, int_next;

    // The valid bits advance on every enabled cycle, including bubbles.
    // A stage's data registers load only when a valid sample arrives, so
    // bubbles leave the stored data untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld <= '0;
        end else if (enable) begin
            vld <= {vld[IPD_STAGES-1:1], in_valid};
        end
    end

    // ---- S1: error and plant-output difference ----
    // y_prev moves only on accepted samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            y_prev <= '0;
            y_p1   <= '0;
            e_p1   <= '0;
            dy_p1  <= '0;
        end else if (enable && in_valid) begin
            y_prev <= y_k;
            y_p1   <= y_k;
            e_p1   <= sat_w(ext(referencia) - ext(y_k));
            dy_p1  <= sat_w(ext(y_k) - ext(y_prev));
        end
    end

    // ---- S2: gain products (live gains) ----
    ipd_fxp_mul #(.WIDTH(WIDTH), .PRECISION(PRECISION)) u_mul_p (
        .a (kp),
        .b (y_p1),
        .p (p_mul)
    );

    ipd_fxp_mul #(.WIDTH(WIDTH), .PRECISION(PRECISION)) u_mul_i (
        .a (ki),
        .b (e_p1),
        .p (inc_mul)
    );

    ipd_fxp_mul #(.WIDTH(WIDTH), .PRECISION(PRECISION)) u_mul_d (
        .a (kd),
        .b (dy_p1),
        .p (d_mul)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            p_p2   <= '0;
            inc_p2 <= '0;
            d_p2   <= '0;
        end else if (enable && vld[1]) begin
            p_p2   <= p_mul;
            inc_p2 <= inc_mul;
            d_p2   <= d_mul;
        end
    end

    // ---- S3: integrator and combined proportional/derivative term ----
    // With anti-windup disabled, AW_EN is a constant 0 and the clamp branch
    // folds away, so the integrator saturates only at the WIDTH range.
    assign int_sum  = sat_w(ext(int_p3) + ext(inc_p2));
    assign int_next = AW_EN ? WIDTH'(ipd_clamp(ext(int_sum), ipd_acc_t'(INT_LIMIT)))
                            : int_sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            p_p3  <= '0;
            d_p3  <= '0;
            pd_p3 <= '0;
        end else if (enable && vld[2]) begin
            p_p3  <= p_p2;
            d_p3  <= d_p2;
            pd_p3 <= sat_w(-ext(p_p2) - ext(d_p2));
        end
    end

    // A clear wins over an update arriving on the same edge. The sample
    // entering S3 on that edge therefore sees an integral of 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            int_p3 <= '0;
        end else if (enable) begin
            if (clear_int) begin
                int_p3 <= '0;
            end else if (vld[2]) begin
                int_p3 <= int_next;
            end
        end
    end

    // ---- S4: control effort plus the matching term monitors ----
    // int_p3 here already includes this sample's own update.
    always_ff @(posedge clock) begin
        if (reset) begin
            u_p4 <= '0;
            p_p4 <= '0;
            d_p4 <= '0;
            i_p4 <= '0;
        end else if (enable && vld[3]) begin
            u_p4 <= sat_w(ext(int_p3) + ext(pd_p3));
            p_p4 <= p_p3;
            d_p4 <= d_p3;
            i_p4 <= int_p3;
        end
    end

    assign out_valid  = vld[IPD_STAGES] & enable;
    assign salida_IPD = u_p4;
    assign prop       = p_p4;
    assign integral   = i_p4;
    assign derivativa = d_p4;

endmodule

// File: tb/tb_ipd_controller.sv
// tb_ipd_controller -- directed bench for ipd_controller.
//
// A sample-level reference model tracks each sample in flight by the number
// of enabled cycles it has spent in the pipeline. A compare process checks
// the DUT against this model on every cycle. Hand-computed literal results
// pin down both the model and the design.
`timescale 1ns/1ps
module tb_ipd_controller;

    localparam int W    = 19;
    localparam int PREC = 0;
`ifdef IPD_ANTIWINDUP_EN
    localparam bit AW   = 1'b1;
    localparam int ILIM = 1000;
`else
    localparam bit AW   = 1'b0;
    localparam int ILIM = 2**(W-1)-1;
`endif
    localparam longint SMAX = 2**(W-1) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic                clock = 1'b0;
    logic                reset, enable, clear_int, in_valid;
    logic signed [W-1:0] referencia, y_k, kp, ki, kd;
    logic                out_valid;
    logic signed [W-1:0] salida_IPD, prop, integral, derivativa;

    ipd_controller #(.WIDTH(W), .PRECISION(PREC), .INT_LIMIT(ILIM)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear_int  (clear_int),
        .in_valid   (in_valid),
        .referencia (referencia),
        .y_k        (y_k),
        .kp         (kp),
        .ki         (ki),
        .kd         (kd),
        .out_valid  (out_valid),
        .salida_IPD (salida_IPD),
        .prop       (prop),
        .integral   (integral),
        .derivativa (derivativa)
    );

    always #5 clock = ~clock;

    typedef struct {
        int     age;
        longint y, e, dy, p, inc, d, i, u;
    } smp_t;

    smp_t   q[$];
    longint m_i = 0, m_yprev = 0;
    longint last_u = 0, last_p = 0, last_i = 0, last_d = 0;
    int     n_cmp = 0, n_bad = 0;
    int     cyc_cnt = 0;
    int     nres = 0;
    int     res_cyc[512];
    longint res_u[512], res_p[512], res_i[512], res_d[512];

    function automatic longint sat(input longint x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    function automatic longint clampi(input longint x);
        if (!AW) return x;
        if (x > ILIM) return ILIM;
        if (x < -ILIM) return -ILIM;
        return x;
    endfunction

    function automatic longint mul(input longint a, input longint b);
        return sat((a * b) >>> PREC);
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Advances the model across the coming clock edge, using this cycle's inputs.
    task automatic model_step();
        int   a2;
        smp_t s;
        if (reset) begin
            q.delete();
            m_i = 0; m_yprev = 0;
            last_u = 0; last_p = 0; last_i = 0; last_d = 0;
            return;
        end
        if (!enable) return;
        a2 = -1;
        foreach (q[k]) begin
            if (q[k].age == 1) begin
                q[k].p   = mul(kp, q[k].y);
                q[k].inc = mul(ki, q[k].e);
                q[k].d   = mul(kd, q[k].dy);
            end
            if (q[k].age == 2) a2 = k;
            if (q[k].age == 3) begin
                last_u = q[k].u; last_p = q[k].p; last_i = q[k].i; last_d = q[k].d;
            end
        end
        if (clear_int) m_i = 0;
        else if (a2 >= 0) m_i = clampi(sat(m_i + q[a2].inc));
        if (a2 >= 0) begin
            q[a2].i = m_i;
            q[a2].u = sat(m_i + sat(-q[a2].p - q[a2].d));
        end
        if (q.size() > 0 && q[0].age == 4) void'(q.pop_front());
        foreach (q[k]) q[k].age++;
        if (in_valid) begin
            s.age = 1;
            s.y   = longint'(y_k);
            s.e   = sat(longint'(referencia) - longint'(y_k));
            s.dy  = sat(longint'(y_k) - m_yprev);
            s.p = 0; s.inc = 0; s.d = 0; s.i = 0; s.u = 0;
            m_yprev = longint'(y_k);
            q.push_back(s);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cyc_cnt++;
        end
    end

    // Compare process: the DUT is checked against the model on every falling edge.
    initial begin
        bit exp_ov;
        forever begin
            @(negedge clock);
            exp_ov = 1'b0;
            foreach (q[k]) if (q[k].age == 4 && enable) exp_ov = 1'b1;
            check("out_valid", out_valid, exp_ov);
            check("salida_IPD", salida_IPD, last_u);
            check("prop", prop, last_p);
            check("integral", integral, last_i);
            check("derivativa", derivativa, last_d);
            if (out_valid === 1'b1 && nres < 512) begin
                res_cyc[nres] = cyc_cnt;
                res_u[nres] = salida_IPD; res_p[nres] = prop;
                res_i[nres] = integral;   res_d[nres] = derivativa;
                nres++;
            end
            model_step();
        end
    end

    task automatic tick(input bit iv, input int r, input int y, input bit en,
                        input bit clr, input bit rst);
        in_valid   = iv;
        referencia = W'(r);
        y_k        = W'(y);
        enable     = en;
        clear_int  = clr;
        reset      = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    endtask

    int base, n0;

    initial begin
        kp = 18; ki = 7; kd = 150;
        do_reset();
        idle(1);
        check("rst_salida", salida_IPD, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_integral", integral, 0);

        // Two consecutive samples from reset.
        base = nres; n0 = cyc_cnt;
        tick(1'b1, 100, 0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 100, 10, 1'b1, 1'b0, 1'b0);
        idle(6);
        check("t1_count", nres - base, 2);
        check("t1_latency", res_cyc[base], n0 + 4);
        check("t1_u0", res_u[base], 700);
        check("t1_i0", res_i[base], 700);
        check("t1_p0", res_p[base], 0);
        check("t1_d0", res_d[base], 0);
        check("t1_p1", res_p[base+1], 180);
        check("t1_d1", res_d[base+1], 1500);
        check("t1_i1", res_i[base+1], AW ? 1000 : 1330);
        check("t1_u1", res_u[base+1], AW ? -680 : -350);

        // Proportional product saturates.
        do_reset();
        kp = 1000; ki = 0; kd = 0;
        base = nres;
        tick(1'b1, 1000, 1000, 1'b1, 1'b0, 1'b0);
        idle(6);
        check("t2_count", nres - base, 1);
        check("t2_prop", res_p[base], 262143);
        check("t2_u", res_u[base], -262143);

        // clear_int in the cycle the sample enters the integrator stage.
        do_reset();
        kp = 18; ki = 7; kd = 150;
        base = nres;
        tick(1'b1, 100, 10, 1'b1, 1'b0, 1'b0);
        idle(1);
        tick(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        idle(5);
        check("t3_count", nres - base, 1);
        check("t3_integral", res_i[base], 0);
        check("t3_u", res_u[base], -1680);
        check("t3_p", res_p[base], 180);

        // Three-cycle stall mid-flight; a strobe during the stall is ignored.
        do_reset();
        base = nres; n0 = cyc_cnt;
        tick(1'b1, 100, 0, 1'b1, 1'b0, 1'b0);
        idle(1);
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 5000, 7, 1'b0, 1'b0, 1'b0);
        idle(6);
        check("t4_count", nres - base, 1);
        check("t4_latency", res_cyc[base], n0 + 7);
        check("t4_u", res_u[base], 700);
        check("t4_i", res_i[base], 700);

        // Eight back-to-back samples.
        do_reset();
        base = nres; n0 = cyc_cnt;
        for (int k = 0; k < 8; k++) tick(1'b1, 100, 5 * k, 1'b1, 1'b0, 1'b0);
        idle(6);
        check("t5_count", nres - base, 8);
        check("t5_first", res_cyc[base], n0 + 4);
        check("t5_span", res_cyc[base+7] - res_cyc[base], 7);
        check("t5_u1", res_u[base+1], AW ? 160 : 525);
        check("t5_u7", res_u[base+7], AW ? -380 : 3240);
        check("t5_i7", res_i[base+7], AW ? 1000 : 4620);

        // Reset two cycles after a sample is taken discards it.
        base = nres;
        tick(1'b1, 100, 0, 1'b1, 1'b0, 1'b0);
        idle(1);
        tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        idle(8);
        check("t6_count", nres - base, 0);
        check("t6_salida", salida_IPD, 0);
        check("t6_prop", prop, 0);
        check("t6_integral", integral, 0);
        check("t6_derivativa", derivativa, 0);

`ifdef IPD_ANTIWINDUP_EN
        // Integrator clamps at INT_LIMIT.
        do_reset();
        kp = 18; ki = 7; kd = 150;
        base = nres;
        for (int k = 0; k < 10; k++) tick(1'b1, 100, 0, 1'b1, 1'b0, 1'b0);
        idle(6);
        check("t7_count", nres - base, 10);
        check("t7_i1", res_i[base+1], 1000);
        check("t7_i9", res_i[base+9], 1000);
        check("t7_u9", res_u[base+9], 1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ipd_controller.md
IPD_CONTROLLER -- requirements
Module: ipd_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 19, signed data width of all data ports.
REQ-002 SHALL have parameter PRECISION, default 0, fractional bits of the fixed-point format (0 <= PRECISION < WIDTH-1).
REQ-003 SHALL have parameter INT_LIMIT, default 2**(WIDTH-1)-1, symmetric integrator clamp magnitude (used only per REQ-024).
REQ-004 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: enable  in  1  pipeline advance; clear_int  in  1  integrator clear.
REQ-006 SHALL have ports: in_valid  in  1  sample strobe; referencia, y_k  in  WIDTH  signed reference and plant output.
REQ-007 SHALL have ports: kp, ki, kd  in  WIDTH  signed gains, same fixed-point format.
REQ-008 SHALL have ports: out_valid  out  1  result strobe; salida_IPD  out  WIDTH  control effort; prop, integral, derivativa  out  WIDTH  term monitors.

Function
REQ-009 SHALL compute e=r-y, dy=y-y_prev, p=kp*y, i_inc=ki*e, d=kd*dy, I=I+i_inc, u=I-p-d, per accepted sample.
REQ-010 SHALL use a 4-stage pipeline: S1 e,dy; S2 p,i_inc,d; S3 I and pd=-p-d; S4 u.
REQ-011 SHALL assert out_valid exactly 4 enabled cycles after the in_valid cycle, one pulse per sample, throughput one sample per cycle.
REQ-012 SHALL treat every add/subtract as WIDTH+1-bit exact then saturate to [-2**(WIDTH-1), 2**(WIDTH-1)-1].
REQ-013 SHALL form each product at 2*WIDTH bits, arithmetic-shift right by PRECISION, then saturate as REQ-012.
REQ-014 SHALL accept a sample only when in_valid=1 and enable=1; y_prev updates only on accepted samples.
REQ-015 SHALL shift per-stage valid bits each enabled cycle; data registers load only when their incoming valid is 1 (bubbles hold data).
REQ-016 SHALL, when enable=0, hold all registers including I and y_prev; out_valid = stage-4 valid AND enable.
REQ-017 SHALL update I only when stage-3 valid and enable are 1.
REQ-018 SHALL, on clear_int=1 with enable=1, load I=0 in that cycle, overriding a simultaneous update.
REQ-019 SHALL drive prop=p, derivativa=d, integral=I as registered at the stage feeding the S4 result of the same sample.
REQ-020 SHALL keep gains unregistered; gain changes take effect on the sample in S2 during that cycle.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, clear all valid bits, I, y_prev and all data registers to 0; reset overrides enable and clear_int.
REQ-022 SHALL hold salida_IPD, prop, integral, derivativa = 0 and out_valid = 0 from reset until the first result.
REQ-023 SHALL discard any in-flight samples on reset mid-operation; no out_valid for them.

Configuration
REQ-024 SHALL, with IPD_ANTIWINDUP_EN defined, clamp I to [-INT_LIMIT, INT_LIMIT] after each update; without it, I saturates only at the WIDTH range and INT_LIMIT is unused.

Structure
REQ-025 SHALL place the saturation limits, the saturate function and the stage-count constant (4) in shared package ipd_pkg.
REQ-026 SHALL implement multiply-shift-saturate as sub-module ipd_fxp_mul, instantiated three times.

Verification (WIDTH=19, PRECISION=0, kp=18, ki=7, kd=150 unless stated)
REQ-027 SHALL check: reset, then r=100, y=0 at cycle n -> out_valid at n+4, salida_IPD=700, integral=700, prop=0, derivativa=0.
REQ-028 SHALL check: next sample r=100, y=10 -> prop=180, derivativa=1500, integral=1330, salida_IPD=-350.
REQ-029 SHALL check: after reset kp=1000, ki=0, kd=0, r=y=1000 -> prop=262143, salida_IPD=-262143.
REQ-030 SHALL check: clear_int coincident with stage-3 valid -> integral=0 for that sample; enable low 3 cycles mid-flight -> result at n+7, values unchanged.
REQ-031 SHALL check: 8 back-to-back samples -> 8 consecutive out_valid pulses; reset at n+2 -> no out_valid, all outputs 0.
REQ-032 SHALL check: with IPD_ANTIWINDUP_EN, INT_LIMIT=1000, ki=7, r=100, y=0 repeated -> integral saturates at 1000.
